mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's memory stage and the data bus (synchronous RAM/peripheral bus with 1-cycle read latency).
- Accepts one request at a time. Issues bus reads for loads and for sub-word stores. Performs read-modify-write for SB/SH. Returns extracted load data with a one-cycle response pulse.
- `busy` stalls the pipeline while an access is in flight.

Parameters:
- ADDR_W, 32, bus/request address width
- DATA_W, 32, bus data width; fixed at 32 for byte-lane logic

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  access request from memory stage
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_rb_op  in  3  load type: LB=0, LBU=1, LH=2, LHU=3, LW=4; 5-7 treated as LW
- req_wdin_op  in  2  store type: SB=0, SH=1, SW=2; 3 treated as SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; holds last value between responses
- busy  out  1  access in flight (state != IDLE)
- misalign  out  1  misaligned-access flag (see Optional Feature)
- Bus_we  out  1  bus write enable
- Bus_addr  out  32  bus address
- Bus_wdata  out  32  bus write data
- Bus_rdata  in  32  bus read data; valid the cycle after a read address is presented

Behaviour:
- Reset: synchronous, active-low.
  - State IDLE.
  - Registers cleared; resp_rdata=0, Bus_addr=0.
  - resp_valid=0, Bus_we=0, misalign=0.
- States: IDLE, RD, WR, RESP. Bus_we is a decode of state: 1 only in WR.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid, latch we/op/addr/wdata. Next state:
    - load -> RD
    - SW -> WR
    - SB/SH -> RD
- RD: Bus_addr=latched addr, Bus_we=0. Next state: load -> RESP; SB/SH -> WR.
- WR:
  - Bus_addr=latched addr, Bus_we=1. Next state -> RESP.
  - Bus_wdata:
    - SW: wdata.
    - SB: merge wdata[7:0] into the live Bus_rdata lane selected by addr[1:0] (lane 0 = bits 7:0).
    - SH: merge wdata[15:0] into the half selected by addr[1].
- RESP:
  - resp_valid=1 for exactly one cycle; next state IDLE.
  - For loads, resp_rdata is updated from Bus_rdata in this cycle and registered for hold.
    - LB/LBU: lane by addr[1:0], sign/zero extend.
    - LH/LHU: half by addr[1], sign/zero extend.
    - LW: full word.
- Latency, counted from the accept cycle 0:
  - Load: resp_valid in cycle 2.
  - SW: write in cycle 1, resp_valid in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, resp_valid in cycle 3.
- Requests are not accepted in RESP; the next accept is earliest in the cycle after RESP.
- req_valid outside IDLE is ignored. Latched fields are immune to request changes mid-access.
- Bus_addr holds its last value in IDLE.
- Reset mid-operation: state returns to IDLE at the reset edge. A pending RMW write is abandoned (Bus_we never asserts), and no resp_valid is produced for the aborted access.
- Address arithmetic: no wrap handling needed; the address is passed through unmodified and the slave ignores bits [1:0].

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned at accept means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - The request is accepted and goes IDLE -> RESP directly; no bus access, Bus_we never 1.
  - In RESP: resp_valid=1, misalign=1, resp_rdata=0.
  - misalign is 0 in every other cycle.
- Undefined:
  - misalign tied 0.
  - Low address bits beyond lane select are ignored: LH at addr 0x3 reads the upper half; LW at 0x6 reads the full word at 0x4.

Test Plan:
- LW addr 0x10, RAM[0x10]=0x87654321 -> resp_valid in cycle 2, resp_rdata=0x87654321, Bus_we never 1, busy high cycles 1-2.
- LB addr 0x13, word 0x80FF0102 -> resp_rdata=0xFFFFFF80. LBU same address -> 0x00000080. LH addr 0x12 -> 0xFFFF80FF.
- SB addr 0x21 wdata 0x000000AB, word 0x11223344 -> cycle 2 Bus_we=1, Bus_wdata=0x1122AB44, resp_valid cycle 3. Follow-up LW returns 0x1122AB44.
- SH addr 0x22 wdata 0x0000BEEF over 0x11223344 -> Bus_wdata=0xBEEF3344. SW addr 0x24 wdata 0xDEADBEEF -> Bus_we in cycle 1, resp cycle 2.
- rst_n low during RD of an SB -> Bus_we never asserts, RAM unchanged, no resp_valid, req_ready=1 the cycle after reset releases.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x06 -> resp_valid cycle 1, misalign=1, resp_rdata=0. SW addr 0x05 -> no bus write. Without the macro: LW 0x06 returns the word at 0x04, misalign=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the memory stage and a 1-cycle-latency data bus; SB/SH use read-modify-write.
// Optional MEM_MISALIGN_TRAP_EN: misaligned requests skip the bus and respond immediately with misalign=1.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_rb_op,
    input  logic [1:0]        req_wdin_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              misalign,
    output logic              Bus_we,
    output logic [ADDR_W-1:0] Bus_addr,
    output logic [DATA_W-1:0] Bus_wdata,
    input  logic [DATA_W-1:0] Bus_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic              we_q;
    logic [2:0]        rb_op_q;
    logic [1:0]        wd_op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mis_q;
    logic              accept;
    logic              sub_word_st;
    logic              req_mis;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    assign accept      = (state == IDLE) && req_valid;
    assign sub_word_st = req_we && (req_wdin_op == 2'd0 || req_wdin_op == 2'd1);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        req_mis = 1'b0;
        if (req_we) begin
            case (req_wdin_op)
                2'd0:    req_mis = 1'b0;
                2'd1:    req_mis = req_addr[0];
                default: req_mis = |req_addr[1:0];
            endcase
        end else begin
            case (req_rb_op)
                3'd0, 3'd1: req_mis = 1'b0;
                3'd2, 3'd3: req_mis = req_addr[0];
                default:    req_mis = |req_addr[1:0];
            endcase
        end
    end
`else
    assign req_mis = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            rb_op_q <= '0;
            wd_op_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= req_we;
                rb_op_q <= req_rb_op;
                wd_op_q <= req_wdin_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mis_q   <= req_mis;
            end
            if (state == RESP)
                rdata_q <= resp_rdata;
        end
    end

    // Sub-word stores read first so the write can merge into the live bus word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_mis)
                        state_next = RESP;
                    else if (!req_we || sub_word_st)
                        state_next = RD;
                    else
                        state_next = WR;
                end
            end
            RD:      state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ld_byte = Bus_rdata[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = Bus_rdata[7:0];
            2'd1: ld_byte = Bus_rdata[15:8];
            2'd2: ld_byte = Bus_rdata[23:16];
            2'd3: ld_byte = Bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? Bus_rdata[31:16] : Bus_rdata[15:0];
        case (rb_op_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {24'd0, ld_byte};
            3'd2:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd3:    ld_data = {16'd0, ld_half};
            default: ld_data = Bus_rdata;
        endcase
    end

    always_comb begin
        resp_rdata = rdata_q;
        if (state == RESP) begin
            if (mis_q)
                resp_rdata = '0;
            else if (!we_q)
                resp_rdata = ld_data;
        end
    end

    always_comb begin
        Bus_wdata = wdata_q;
        case (wd_op_q)
            2'd0: begin
                case (addr_q[1:0])
                    2'd0: Bus_wdata = {Bus_rdata[31:8], wdata_q[7:0]};
                    2'd1: Bus_wdata = {Bus_rdata[31:16], wdata_q[7:0], Bus_rdata[7:0]};
                    2'd2: Bus_wdata = {Bus_rdata[31:24], wdata_q[7:0], Bus_rdata[15:0]};
                    2'd3: Bus_wdata = {wdata_q[7:0], Bus_rdata[23:0]};
                endcase
            end
            2'd1: Bus_wdata = addr_q[1] ? {wdata_q[15:0], Bus_rdata[15:0]}
                                        : {Bus_rdata[31:16], wdata_q[15:0]};
            default: Bus_wdata = wdata_q;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign Bus_we     = (state == WR);
    assign Bus_addr   = addr_q;
    assign misalign   = (state == RESP) && mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table driven through a scoreboard, plus a reset-abort sequence.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-address vectors.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_rb_op;
    logic [1:0]  req_wdin_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        misalign;
    logic        Bus_we;
    logic [31:0] Bus_addr;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_rb_op  (req_rb_op),
        .req_wdin_op(req_wdin_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .misalign   (misalign),
        .Bus_we     (Bus_we),
        .Bus_addr   (Bus_addr),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata)
    );

    // Synchronous RAM with one-cycle read latency; the preload port lets the bench seed words while idle.
    logic [31:0] ram [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        Bus_rdata <= ram[Bus_addr[7:2]];
        if (Bus_we)
            ram[Bus_addr[7:2]] <= Bus_wdata;
        else if (pl_en)
            ram[pl_idx] <= pl_data;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  rb_op;
        logic [1:0]  wd_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        preload;
        logic [31:0] init_word;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_wr;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic add(input string n, input logic we, input logic [2:0] rb, input logic [1:0] wd,
                       input logic [31:0] a, input logic [31:0] wdat, input logic pre,
                       input logic [31:0] init, input logic [31:0] exp_r, input logic [31:0] exp_w,
                       input int lat, input int wr, input logic mis);
        vec_t v;
        v.name = n; v.we = we; v.rb_op = rb; v.wd_op = wd; v.addr = a; v.wdata = wdat;
        v.preload = pre; v.init_word = init; v.exp_rdata = exp_r; v.exp_word = exp_w;
        v.exp_lat = lat; v.exp_wr = wr; v.exp_mis = mis;
        vecs.push_back(v);
    endtask

    // Stores and trapped accesses do not load: resp_rdata holds the previous value or reads 0.
    task automatic applyStimulus(input vec_t vin);
        vec_t v;
        v = vin;
        @(negedge clk);
        if (v.preload) begin
            pl_en   = 1'b1;
            pl_idx  = v.addr[7:2];
            pl_data = v.init_word;
            @(negedge clk);
            pl_en = 1'b0;
        end
        check({v.name, " req_ready before accept"}, {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_we      = v.we;
        req_rb_op   = v.rb_op;
        req_wdin_op = v.wd_op;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        if (v.exp_mis)
            v.exp_rdata = 32'd0;
        else if (v.we)
            v.exp_rdata = last_rdata;
        last_rdata = v.exp_rdata;
        sb_q.push_back(v);
        @(posedge clk);
    endtask

    // Keeps req_valid high with scrambled fields while busy to prove requests are ignored mid-access.
    task automatic checkOutput();
        vec_t        v;
        int          cyc      = 0;
        int          resp_cyc = -1;
        int          wr_cyc   = -1;
        int          wr_cnt   = 0;
        logic        busy_ok  = 1'b1;
        logic        mis_stray = 1'b0;
        logic        mis_seen = 1'b0;
        logic [31:0] rdata_seen = 32'd0;
        logic [31:0] addr_seen  = 32'd0;
        v = sb_q.pop_front();
        while (resp_cyc < 0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (Bus_we) begin
                wr_cnt++;
                if (wr_cyc < 0) wr_cyc = cyc;
            end
            if (!busy) busy_ok = 1'b0;
            if (resp_valid) begin
                resp_cyc   = cyc;
                rdata_seen = resp_rdata;
                mis_seen   = misalign;
                addr_seen  = Bus_addr;
            end else if (misalign) begin
                mis_stray = 1'b1;
            end
            req_valid   = 1'b1;
            req_we      = 1'($urandom);
            req_rb_op   = 3'($urandom);
            req_wdin_op = 2'($urandom);
            req_addr    = $urandom;
            req_wdata   = $urandom;
        end
        check({v.name, " resp latency"}, 32'(resp_cyc), 32'(v.exp_lat));
        check({v.name, " resp_rdata"}, rdata_seen, v.exp_rdata);
        check({v.name, " misalign in resp"}, {31'd0, mis_seen}, {31'd0, v.exp_mis});
        check({v.name, " misalign outside resp"}, {31'd0, mis_stray}, 32'd0);
        check({v.name, " write cycle"}, 32'(wr_cyc), 32'(v.exp_wr));
        check({v.name, " write count"}, 32'(wr_cnt), (v.exp_wr >= 0) ? 32'd1 : 32'd0);
        check({v.name, " busy while in flight"}, {31'd0, busy_ok}, 32'd1);
        if (!v.exp_mis)
            check({v.name, " Bus_addr"}, addr_seen, v.addr);
        @(negedge clk);
        check({v.name, " resp_valid one cycle"}, {31'd0, resp_valid}, 32'd0);
        check({v.name, " idle after resp"}, {30'd0, busy, req_ready}, 32'd1);
        check({v.name, " RAM word"}, ram[v.addr[7:2]], v.exp_word);
        req_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen_we;
        logic seen_resp;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_rb_op = 3'd0; req_wdin_op = 2'd0;
        req_addr = 32'd0; req_wdata = 32'd0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset Bus_we", {31'd0, Bus_we}, 32'd0);
        check("reset misalign", {31'd0, misalign}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset Bus_addr", Bus_addr, 32'd0);
        rst_n = 1'b1;

        //   name           we rb wd addr   wdata       pre init          exp_rdata     exp_word      lat wr mis
        add("LW 0x10",      0, 4, 0, 32'h10, 32'h0,       1, 32'h87654321, 32'h87654321, 32'h87654321, 2, -1, 0);
        add("LB 0x13",      0, 0, 0, 32'h13, 32'h0,       1, 32'h80FF0102, 32'hFFFFFF80, 32'h80FF0102, 2, -1, 0);
        add("LBU 0x13",     0, 1, 0, 32'h13, 32'h0,       1, 32'h80FF0102, 32'h00000080, 32'h80FF0102, 2, -1, 0);
        add("LH 0x12",      0, 2, 0, 32'h12, 32'h0,       1, 32'h80FF0102, 32'hFFFF80FF, 32'h80FF0102, 2, -1, 0);
        add("LHU 0x12",     0, 3, 0, 32'h12, 32'h0,       1, 32'h80FF0102, 32'h000080FF, 32'h80FF0102, 2, -1, 0);
        add("LB 0x10",      0, 0, 0, 32'h10, 32'h0,       1, 32'h80FF0102, 32'h00000002, 32'h80FF0102, 2, -1, 0);
        add("LH 0x10",      0, 2, 0, 32'h10, 32'h0,       1, 32'h80FF0102, 32'h00000102, 32'h80FF0102, 2, -1, 0);
        add("SB 0x21",      1, 0, 0, 32'h21, 32'h000000AB, 1, 32'h11223344, 32'h0,        32'h1122AB44, 3, 2, 0);
        add("LW 0x20",      0, 4, 0, 32'h20, 32'h0,       0, 32'h0,        32'h1122AB44, 32'h1122AB44, 2, -1, 0);
        add("SH 0x22",      1, 0, 1, 32'h22, 32'h0000BEEF, 1, 32'h11223344, 32'h0,        32'hBEEF3344, 3, 2, 0);
        add("SW 0x24",      1, 0, 2, 32'h24, 32'hDEADBEEF, 1, 32'h00000000, 32'h0,        32'hDEADBEEF, 2, 1, 0);
        add("LW op7 0x24",  0, 7, 0, 32'h24, 32'h0,       0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2, -1, 0);
        add("SB 0x27",      1, 0, 0, 32'h27, 32'h123456CD, 1, 32'hFFFFFFFF, 32'h0,        32'hCDFFFFFF, 3, 2, 0);
        add("SH 0x28",      1, 0, 1, 32'h28, 32'hFFFF1357, 1, 32'hAAAAAAAA, 32'h0,        32'hAAAA1357, 3, 2, 0);
        add("SW op3 0x2C",  1, 0, 3, 32'h2C, 32'hCAFEF00D, 1, 32'h00000000, 32'h0,        32'hCAFEF00D, 2, 1, 0);
        add("LBU 0x2E",     0, 1, 0, 32'h2E, 32'h0,       0, 32'h0,        32'h000000FE, 32'hCAFEF00D, 2, -1, 0);
        add("LB 0x2D",      0, 0, 0, 32'h2D, 32'h0,       0, 32'h0,        32'hFFFFFFF0, 32'hCAFEF00D, 2, -1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        add("LW 0x06 trap", 0, 4, 0, 32'h06, 32'h0,       1, 32'h55AA1234, 32'h0,        32'h55AA1234, 1, -1, 1);
        add("LH 0x03 trap", 0, 2, 0, 32'h03, 32'h0,       1, 32'h80017FFF, 32'h0,        32'h80017FFF, 1, -1, 1);
        add("SW 0x05 trap", 1, 0, 2, 32'h05, 32'h99999999, 1, 32'h01020304, 32'h0,        32'h01020304, 1, -1, 1);
        add("LHU 0x05 trap",0, 3, 0, 32'h05, 32'h0,       0, 32'h0,        32'h0,        32'h01020304, 1, -1, 1);
`else
        add("LW 0x06",      0, 4, 0, 32'h06, 32'h0,       1, 32'h55AA1234, 32'h55AA1234, 32'h55AA1234, 2, -1, 0);
        add("LH 0x03",      0, 2, 0, 32'h03, 32'h0,       1, 32'h80017FFF, 32'hFFFF8001, 32'h80017FFF, 2, -1, 0);
        add("SW 0x05",      1, 0, 2, 32'h05, 32'h99999999, 1, 32'h01020304, 32'h0,        32'h99999999, 2, 1, 0);
        add("LHU 0x05",     0, 3, 0, 32'h05, 32'h0,       0, 32'h0,        32'h00009999, 32'h99999999, 2, -1, 0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Reset asserted while an SB sits in its read cycle: the merge write must never happen.
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 6'd12; pl_data = 32'h11223344;
        @(negedge clk);
        pl_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_wdin_op = 2'd0; req_rb_op = 3'd0;
        req_addr = 32'h30; req_wdata = 32'h000000EE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        check("abort busy in read cycle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("abort busy after reset", {31'd0, busy}, 32'd0);
        check("abort Bus_addr after reset", Bus_addr, 32'd0);
        check("abort resp_rdata after reset", resp_rdata, 32'd0);
        rst_n = 1'b1;
        seen_we = 1'b0;
        seen_resp = 1'b0;
        @(negedge clk);
        check("abort req_ready after release", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (Bus_we) seen_we = 1'b1;
            if (resp_valid) seen_resp = 1'b1;
            @(negedge clk);
        end
        check("abort no bus write", {31'd0, seen_we}, 32'd0);
        check("abort no response", {31'd0, seen_resp}, 32'd0);
        check("abort RAM unchanged", ram[12], 32'h11223344);

        last_rdata = 32'd0;
        applyStimulus('{name: "LW 0x30 after abort", we: 1'b0, rb_op: 3'd4, wd_op: 2'd0, addr: 32'h30,
                        wdata: 32'h0, preload: 1'b0, init_word: 32'h0, exp_rdata: 32'h11223344,
                        exp_word: 32'h11223344, exp_lat: 2, exp_wr: -1, exp_mis: 1'b0});
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
